// File: rtl/fetch_unit_32.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// holds the fetched instruction for decode and selects the next PC at retire.
module fetch_unit_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] jr_target,
  output logic        err_misaligned,
  output logic        err_imem_timeout
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_mis_q, err_mis_d;
  logic        err_to_q, err_to_d;
  logic [7:0]  timer_q, timer_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  logic [7:0]  timer_inc_s;

  assign pc_plus4_s  = pc_q + 32'd4;
  assign timer_inc_s = timer_q + 8'd1;

  // Next-PC selection in priority order: jr, j/jal, taken branch, sequential.
  always_comb begin
    next_pc_s = pc_plus4_s;
    case (jump_sel)
      2'b10:   next_pc_s = jr_target;
      2'b01:   next_pc_s = {pc_plus4_s[31:28], instr_q[25:0], 2'b00};
      default: begin
        if (branch_taken) begin
          next_pc_s = branch_target;
        end else begin
          next_pc_s = pc_plus4_s;
        end
      end
    endcase
  end

  // Fetch FSM next-state and datapath updates; everything holds by default.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    err_mis_d = err_mis_q;
    err_to_d  = err_to_q;
    timer_d   = timer_q;
    case (state_q)
      S_FETCH: begin
        req_d   = 1'b1;
        addr_d  = pc_q;
        timer_d = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          timer_d = timer_inc_s;
          // Abandon the request but remember an ack is still owed.
          if ((TIMEOUT != 8'd0) && (timer_inc_s == TIMEOUT)) begin
            err_to_d = 1'b1;
            req_d    = 1'b0;
            state_d  = S_DRAIN;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if (next_pc_s[1:0] != 2'b00) begin
            err_mis_d = 1'b1;
          end else begin
            err_mis_d = err_mis_q;
          end
          pc_d    = next_pc_s & 32'hFFFF_FFFC;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        state_d = S_FETCH;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      instr_q   <= 32'd0;
      valid_q   <= 1'b0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
      timer_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      err_mis_q <= err_mis_d;
      err_to_q  <= err_to_d;
      timer_q   <= timer_d;
    end
  end

  assign imem_req         = req_q;
  assign imem_addr        = addr_q;
  assign instr            = instr_q;
  assign opcode           = instr_q[31:26];
  assign instr_valid      = valid_q;
  assign pc               = pc_q;
  assign pc_plus4         = pc_plus4_s;
  assign err_misaligned   = err_mis_q;
  assign err_imem_timeout = err_to_q;

endmodule

// File: tb/tb_fetch_unit_32.sv
// Randomized bench for fetch_unit_32: the bench plays instruction memory and
// predicts every fetch address from the next-PC priority rules.
module tb_fetch_unit_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [1:0]  jump_sel;
  logic [31:0] jr_target;
  logic        err_misaligned;
  logic        err_imem_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_err_mis;
  logic        m_err_to;

  fetch_unit_32 #(.RESET_PC(32'h0000_0400), .TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_sel(jump_sel), .jr_target(jr_target),
    .err_misaligned(err_misaligned), .err_imem_timeout(err_imem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] cur_instr,
                                           input logic [1:0] js, input logic bt,
                                           input logic [31:0] btgt, input logic [31:0] jtgt);
    logic [31:0] p4;
    p4 = cur_pc + 32'd4;
    if (js == 2'b10)      return jtgt;
    else if (js == 2'b01) return {p4[31:28], cur_instr[25:0], 2'b00};
    else if (bt)          return btgt;
    else                  return p4;
  endfunction

  task automatic randomize_redirect();
    jump_sel      = 2'($urandom_range(0, 3));
    branch_taken  = 1'($urandom_range(0, 1));
    branch_target = $urandom;
    jr_target     = $urandom;
  endtask

  task automatic reset_model();
    m_pc      = 32'h0000_0400;
    m_instr   = 32'd0;
    m_err_mis = 1'b0;
    m_err_to  = 1'b0;
  endtask

  // Wait for a request, answer after d cycles with data, then check the held instruction.
  task automatic do_fetch(input int d, input logic [31:0] data, output int wait_cyc);
    wait_cyc = 0;
    while (!imem_req && wait_cyc < 10) begin
      tick();
      wait_cyc++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    check("imem_addr", imem_addr, m_pc);
    for (int k = 0; k < d; k++) begin
      tick();
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_stable", imem_addr, m_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_instr    = data;
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("instr", instr, data);
    check("opcode", 32'(opcode), 32'(data[31:26]));
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("req_dropped", 32'(imem_req), 32'd0);
  endtask

  // Stall s cycles with noisy redirect inputs, then retire with the given redirect.
  task automatic do_hold(input int s, input logic [1:0] js, input logic bt,
                         input logic [31:0] btgt, input logic [31:0] jtgt);
    logic [31:0] nxt;
    for (int k = 0; k < s; k++) begin
      stall = 1'b1;
      randomize_redirect();
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", instr, m_instr);
      check("stall_pc", pc, m_pc);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_err_mis", 32'(err_misaligned), 32'(m_err_mis));
    end
    stall         = 1'b0;
    jump_sel      = js;
    branch_taken  = bt;
    branch_target = btgt;
    jr_target     = jtgt;
    nxt = ref_next(m_pc, m_instr, js, bt, btgt, jtgt);
    if (nxt[1:0] != 2'b00) m_err_mis = 1'b1;
    m_pc = nxt & 32'hFFFF_FFFC;
    tick();
    randomize_redirect();
    check("retire_valid", 32'(instr_valid), 32'd0);
    check("err_misaligned", 32'(err_misaligned), 32'(m_err_mis));
    check("err_timeout", 32'(err_imem_timeout), 32'(m_err_to));
  endtask

  initial begin
    int wc;
    logic [31:0] bt_t, jr_t;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0; jump_sel = 2'b00; jr_target = 32'd0;
    reset_model();
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc, 32'h0000_0400);
    check("rst_errs", {30'd0, err_misaligned, err_imem_timeout}, 32'd0);

    // Minimum latency out of reset, then a 5-cycle stall and sequential advance.
    rst = 1'b0;
    do_fetch(0, 32'h2108_0001, wc);
    check("t1_latency", 32'(wc), 32'd1);
    do_hold(5, 2'b00, 1'b0, 32'd0, 32'd0);
    do_fetch(1, 32'h0000_0000, wc);
    check("t1_next_pc", pc, 32'h0000_0404);

    // j from 0x0040_0010.
    do_hold(0, 2'b10, 1'b0, 32'd0, 32'h0040_0010);
    do_fetch(0, 32'h0810_0040, wc);
    do_hold(0, 2'b01, 1'b0, 32'd0, 32'd0);
    do_fetch(0, 32'h0000_0000, wc);
    check("t3_j_target", pc, 32'h0040_0100);

    // jr beats a taken branch; jump_sel=11 falls through to pc+4.
    do_hold(1, 2'b10, 1'b1, 32'h0000_2000, 32'h0000_1000);
    do_fetch(2, $urandom, wc);
    check("t4_jr_prio", pc, 32'h0000_1000);
    do_hold(0, 2'b11, 1'b0, 32'h0000_2000, 32'h0000_3000);
    do_fetch(0, $urandom, wc);
    check("t4_js11", pc, 32'h0000_1004);

    // Timeout after 4 WAIT cycles, drain a late ack, then retry the same pc.
    do_hold(0, 2'b00, 1'b0, 32'd0, 32'd0);
    wc = 0;
    while (!imem_req && wc < 10) begin tick(); wc++; end
    check("to_req_seen", 32'(imem_req), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("to_req_held", 32'(imem_req), 32'd1);
      check("to_err_early", 32'(err_imem_timeout), 32'd0);
    end
    tick();
    m_err_to = 1'b1;
    check("to_req_drop", 32'(imem_req), 32'd0);
    check("to_err_set", 32'(err_imem_timeout), 32'd1);
    repeat (2) begin
      tick();
      check("drain_req", 32'(imem_req), 32'd0);
      check("drain_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("drain_discard", 32'(instr_valid), 32'd0);
    tick();
    check("retry_req", 32'(imem_req), 32'd1);
    check("retry_addr", imem_addr, 32'h0000_1008);
    do_fetch(1, 32'h1234_5678, wc);

    // Misaligned jr, then wrap of the sequential PC.
    do_hold(0, 2'b10, 1'b0, 32'd0, 32'h0000_1002);
    check("t5_err_mis", 32'(err_misaligned), 32'd1);
    do_fetch(0, $urandom, wc);
    check("t5_aligned", pc, 32'h0000_1000);
    do_hold(0, 2'b10, 1'b0, 32'd0, 32'hFFFF_FFFC);
    do_fetch(0, 32'h0000_0000, wc);
    check("t5_wrap_p4", pc_plus4, 32'h0000_0000);
    do_hold(0, 2'b00, 1'b0, 32'd0, 32'd0);
    do_fetch(0, $urandom, wc);
    check("t5_wrap_pc", pc, 32'h0000_0000);

    // Reset during WAIT, with an ack in the first cycle after reset drops.
    do_hold(0, 2'b00, 1'b0, 32'd0, 32'd0);
    wc = 0;
    while (!imem_req && wc < 10) begin tick(); wc++; end
    rst = 1'b1;
    tick();
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_pc", pc, 32'h0000_0400);
    check("mid_rst_errs", {30'd0, err_misaligned, err_imem_timeout}, 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    reset_model();
    check("post_rst_ack_ignored", 32'(instr_valid), 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd1);

    // Randomized fetch/redirect traffic.
    for (int i = 0; i < 150; i++) begin
      do_fetch($urandom_range(0, 2), $urandom, wc);
      bt_t = $urandom;
      jr_t = $urandom;
      if ($urandom_range(0, 3) != 0) bt_t[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jr_t[1:0] = 2'b00;
      do_hold($urandom_range(0, 3), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), bt_t, jr_t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
